fmsynth_seq: RTL and testbench
==============================

Name: fmsynth_seq

Overview:
- Timed register-write sequencer and bus arbiter in front of fmsynth.
- CPU pre-loads a FIFO of commands: register writes and sample-tick delays. The block replays them on the fmsynth bus without CPU timing involvement.
- Also arbitrates between that player and direct CPU accesses to fmsynth, so note-on/off scripts run sample-accurately.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (41 bits each: is_wait, addr[7:0], data[31:0]).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ctl_addr  in  2  sequencer register select
- ctl_wrdata  in  32  sequencer register write data
- ctl_wren  in  1  sequencer register write strobe (single cycle, never waits)
- ctl_rddata  out  32  sequencer register read data (combinational on ctl_addr)
- cpu_fm_addr  in  8  direct CPU fmsynth address
- cpu_fm_wrdata  in  32  direct CPU write data
- cpu_fm_wren  in  1  direct CPU write request
- cpu_fm_rden  in  1  direct CPU read request
- cpu_fm_rddata  out  32  fm_rddata passthrough
- cpu_fm_wait  out  1  stall to CPU
- fm_addr  out  8  to fmsynth bus_addr
- fm_wrdata  out  32  to fmsynth bus_wrdata
- fm_wren  out  1  to fmsynth bus_wren
- fm_rddata  in  32  from fmsynth bus_rddata
- fm_wait  in  1  from fmsynth bus_wait
- sample_tick  in  1  one-cycle pulse per audio sample
- irq  out  1  low-water interrupt (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FIFO empty, run=0, overflow=0, staged=0, state IDLE, owner=CPU.

Registers:
- 0 STAGE (RW): [8]=is_wait, [7:0]=addr.
- 1 PUSH (W): pushes {STAGE[8], STAGE[7:0], wrdata}. Reads 0.
- 2 CTRL/STATUS:
  - Write: [0] run, [1] flush (self-clearing), [2] clear overflow.
  - Read: [0] run, [1] busy (state != IDLE), [2] overflow, [3] empty, [4] full, [15:8] count.
- 3 LWM (see Optional Feature).

FIFO:
- Push while full: entry dropped, overflow set (sticky).
- Push and pop in the same cycle: count unchanged.
- Flush: count=0 next cycle; also applies when asserted together with a push (the push is discarded).

Player FSM:
- IDLE → FETCH when run && !empty && !cpu_req, where cpu_req = cpu_fm_wren | cpu_fm_rden. The pop happens on this edge.
- FETCH: head entry registered.
  - is_wait=0 → WRITE.
  - is_wait=1 → load counter from data[15:0]. If the value is 0 → IDLE, else → WAIT_TICKS.
- WRITE: owner=PLAYER; fm_wren=1, fm_addr/fm_wrdata from the entry, held stable. Completes at the posedge where fm_wait=0 → IDLE.
  - Minimum throughput: one write per 3 cycles.
- WAIT_TICKS: decrement on sample_tick when run=1; frozen when run=0. Reaching 0 → IDLE.
  - Flush → IDLE next cycle.
- Flush or run=0 never aborts WRITE; the write completes.

Arbitration:
- fm_* is muxed combinationally by owner.
- Owner=CPU whenever the player is not in WRITE. cpu_fm_* passes through; cpu_fm_wait = fm_wait.
- While the player is in WRITE: cpu_fm_wait = cpu_req, and CPU strobes are not forwarded.
- A pending CPU request blocks IDLE→FETCH, so the CPU always wins between player transactions. No preemption mid-transaction.

Async reset mid-WRITE: fm_wren drops immediately; the entry is lost.

Optional Feature:
- Macro FMSYNTH_SEQ_IRQ_EN.
- Defined:
  - Register 3 LWM[7:0] (RW, reset 0).
  - irq registered, = run && (count <= LWM) && !flush. Level-sensitive; clears when refilled above LWM.
- Undefined: irq tied 0; register 3 reads 0, writes ignored.

Test Plan:
- Push STAGE=0x060, PUSH=0x0000212C (KON=1, FNUM=300), then CTRL=1 → fm_wren rises 2 cycles after run with addr 0x60, data 0x212C. fm_wait held 3 cycles → fm_wren stable for 4 cycles, then 0; status empty=1, busy=0.
- Queue {wait 100}, {0x60, 0x0000012C}, run → second write's fm_wren asserts only after the 100th sample_tick, and within 3 cycles of it.
- Player in WRITE with fm_wait=1, CPU asserts cpu_fm_wren addr 0x80 → cpu_fm_wait=1 until the player completes. Then fm_addr=0x80, and the CPU write passes through before the next player FETCH.
- DEPTH_LOG2=4, run=0, 17 pushes → count=16, full=1, overflow=1, 17th entry absent on replay. CTRL bit2 write → overflow=0.
- Flush during WAIT_TICKS (counter 50) → busy=0 and count=0 next cycle; no further fm_wren.
- Async reset asserted mid-WRITE, between clock edges → fm_wren=0 immediately; after release, status reads 0x0008.

Source files
------------

// File: rtl/fmsynth_seq.sv
// fmsynth_seq: FIFO-driven timed register-write player plus CPU/player fmsynth bus arbiter.
// Define FMSYNTH_SEQ_IRQ_EN to add the LWM register (addr 3) and the low-water irq.
module fmsynth_seq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ctl_addr,
  input  logic [31:0] ctl_wrdata,
  input  logic        ctl_wren,
  output logic [31:0] ctl_rddata,
  input  logic [7:0]  cpu_fm_addr,
  input  logic [31:0] cpu_fm_wrdata,
  input  logic        cpu_fm_wren,
  input  logic        cpu_fm_rden,
  output logic [31:0] cpu_fm_rddata,
  output logic        cpu_fm_wait,
  output logic [7:0]  fm_addr,
  output logic [31:0] fm_wrdata,
  output logic        fm_wren,
  input  logic [31:0] fm_rddata,
  input  logic        fm_wait,
  input  logic        sample_tick,
  output logic        irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] P1 = 1;
  localparam logic [CW-1:0] C1 = 1;
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t                r_state;
  logic [40:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic [8:0]            r_stage;
  logic                  r_run;
  logic                  r_ovf;
  logic [40:0]           r_ent;
  logic [15:0]           r_ticks;

  logic       w_cpu_req;
  logic       w_ctrl_wr;
  logic       w_push;
  logic       w_push_ok;
  logic       w_flush;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_owner;
  logic       w_busy;
  logic [7:0] w_cnt8;

  assign w_cpu_req = cpu_fm_wren | cpu_fm_rden;
  assign w_ctrl_wr = ctl_wren && (ctl_addr == 2'd2);
  assign w_push    = ctl_wren && (ctl_addr == 2'd1);
  assign w_flush   = w_ctrl_wr && ctl_wrdata[1];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CFULL);
  assign w_push_ok = w_push && !w_full && !w_flush;
  assign w_cnt8    = 8'(r_count);
  assign w_busy    = (r_state != S_IDLE);
  assign w_owner   = (r_state == S_WRITE);

  // A pending CPU request holds the player off between transactions.
  assign w_pop = (r_state == S_IDLE) && r_run && !w_empty
              && !w_cpu_req && !w_flush;

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= {r_stage, ctl_wrdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok)
        r_wptr <= r_wptr + P1;
      if (w_pop)
        r_rptr <= r_rptr + P1;
      if (w_push_ok && !w_pop)
        r_count <= r_count + C1;
      else if (!w_push_ok && w_pop)
        r_count <= r_count - C1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
      r_run   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (ctl_wren && (ctl_addr == 2'd0))
        r_stage <= ctl_wrdata[8:0];
      if (w_ctrl_wr)
        r_run <= ctl_wrdata[0];
      if (w_ctrl_wr && ctl_wrdata[2])
        r_ovf <= 1'b0;
      else if (w_push && w_full && !w_flush)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ent   <= '0;
      r_ticks <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_ent   <= r_mem[r_rptr];
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!r_ent[40]) begin
            r_state <= S_WRITE;
          end else begin
            r_ticks <= r_ent[15:0];
            r_state <= (r_ent[15:0] == 16'd0) ? S_IDLE : S_WAIT;
          end
        end
        S_WRITE: begin
          if (!fm_wait)
            r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (w_flush) begin
            r_state <= S_IDLE;
          end else if (r_run && sample_tick) begin
            r_ticks <= r_ticks - 16'd1;
            if (r_ticks == 16'd1)
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fm_addr       = w_owner ? r_ent[39:32] : cpu_fm_addr;
  assign fm_wrdata     = w_owner ? r_ent[31:0]  : cpu_fm_wrdata;
  assign fm_wren       = w_owner ? 1'b1         : cpu_fm_wren;
  assign cpu_fm_wait   = w_owner ? w_cpu_req    : fm_wait;
  assign cpu_fm_rddata = fm_rddata;

`ifdef FMSYNTH_SEQ_IRQ_EN
  logic [7:0] r_lwm;
  logic       r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lwm <= '0;
      r_irq <= 1'b0;
    end else begin
      if (ctl_wren && (ctl_addr == 2'd3))
        r_lwm <= ctl_wrdata[7:0];
      r_irq <= r_run && (w_cnt8 <= r_lwm) && !w_flush;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    ctl_rddata = '0;
    unique case (ctl_addr)
      2'd0: ctl_rddata = {23'd0, r_stage};
      2'd1: ctl_rddata = '0;
      2'd2: ctl_rddata = {16'd0, w_cnt8, 3'd0, w_full,
                          w_empty, r_ovf, w_busy, r_run};
`ifdef FMSYNTH_SEQ_IRQ_EN
      2'd3: ctl_rddata = {24'd0, r_lwm};
`else
      2'd3: ctl_rddata = '0;
`endif
    endcase
  end

endmodule

// File: tb/tb_fmsynth_seq.sv
// tb_fmsynth_seq: directed stimulus; expected fm bus writes queued and
// checked by an independent bus monitor.
module tb_fmsynth_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ctl_addr = '0;
  logic [31:0] ctl_wrdata = '0;
  logic        ctl_wren = 1'b0;
  logic [31:0] ctl_rddata;
  logic [7:0]  cpu_fm_addr = '0;
  logic [31:0] cpu_fm_wrdata = '0;
  logic        cpu_fm_wren = 1'b0;
  logic        cpu_fm_rden = 1'b0;
  logic [31:0] cpu_fm_rddata;
  logic        cpu_fm_wait;
  logic [7:0]  fm_addr;
  logic [31:0] fm_wrdata;
  logic        fm_wren;
  logic [31:0] fm_rddata = 32'hCAFE_0001;
  logic        fm_wait = 1'b0;
  logic        sample_tick = 1'b0;
  logic        irq;

  int n_tests = 0;
  int n_fail = 0;
  logic [39:0] sb[$];
  logic [39:0] mon_exp;

  fmsynth_seq #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset),
    .ctl_addr(ctl_addr), .ctl_wrdata(ctl_wrdata),
    .ctl_wren(ctl_wren), .ctl_rddata(ctl_rddata),
    .cpu_fm_addr(cpu_fm_addr), .cpu_fm_wrdata(cpu_fm_wrdata),
    .cpu_fm_wren(cpu_fm_wren), .cpu_fm_rden(cpu_fm_rden),
    .cpu_fm_rddata(cpu_fm_rddata), .cpu_fm_wait(cpu_fm_wait),
    .fm_addr(fm_addr), .fm_wrdata(fm_wrdata), .fm_wren(fm_wren),
    .fm_rddata(fm_rddata), .fm_wait(fm_wait),
    .sample_tick(sample_tick), .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus monitor: a write is accepted at the posedge following a sample
  // with fm_wren=1 and fm_wait=0.
  always @(negedge clk) begin
    if (!reset && fm_wren && !fm_wait) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL fm_write_unexpected: got addr=%h data=%h, required none",
                 fm_addr, fm_wrdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({fm_addr, fm_wrdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL fm_write: got addr=%h data=%h, required addr=%h data=%h",
                   fm_addr, fm_wrdata, mon_exp[39:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic ctl_write(input logic [1:0] a, input logic [31:0] d);
    ctl_addr   = a;
    ctl_wrdata = d;
    ctl_wren   = 1'b1;
    tick();
    ctl_wren   = 1'b0;
  endtask

  task automatic ctl_read(input logic [1:0] a, output logic [31:0] d);
    ctl_addr = a;
    #1;
    d = ctl_rddata;
  endtask

  task automatic push(input logic [8:0] stage, input logic [31:0] d);
    ctl_write(2'd0, {23'd0, stage});
    ctl_write(2'd1, d);
  endtask

  logic [31:0] rd;
  int lat;
  int early;
  int guard;

  initial begin
    // Reset state
    #1;
    check("reset_fm_wren", {31'd0, fm_wren}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_cpu_fm_wait", {31'd0, cpu_fm_wait}, 32'd0);
    ctl_read(2'd2, rd);
    check("reset_status", rd, 32'h0000_0008);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // LWM register presence
    ctl_write(2'd3, 32'd5);
    ctl_read(2'd3, rd);
`ifdef FMSYNTH_SEQ_IRQ_EN
    check("lwm_readback", rd, 32'd5);
`else
    check("lwm_readback", rd, 32'd0);
`endif
    check("irq_idle", {31'd0, irq}, 32'd0);
    check("rddata_pass", cpu_fm_rddata, 32'hCAFE_0001);

    // Single write, fm_wait held for 3 cycles
    push(9'h060, 32'h0000_212C);
    sb.push_back({8'h60, 32'h0000_212C});
    fm_wait = 1'b1;
    ctl_write(2'd2, 32'd1);
    check("t1_wren_e0", {31'd0, fm_wren}, 32'd0);
    tick();
    check("t1_wren_e1", {31'd0, fm_wren}, 32'd0);
    tick();
    check("t1_wren_e2", {31'd0, fm_wren}, 32'd1);
    check("t1_addr", {24'd0, fm_addr}, 32'h60);
    check("t1_data", fm_wrdata, 32'h0000_212C);
    tick();
    check("t1_wren_e3", {31'd0, fm_wren}, 32'd1);
    tick();
    check("t1_wren_e4", {31'd0, fm_wren}, 32'd1);
    tick();
    check("t1_wren_e5", {31'd0, fm_wren}, 32'd1);
    fm_wait = 1'b0;
    tick();
    check("t1_wren_done", {31'd0, fm_wren}, 32'd0);
    ctl_read(2'd2, rd);
    check("t1_status", rd, 32'h0000_0009);
    ctl_write(2'd2, 32'd0);

    // Wait 100 ticks, then a write
    push(9'h100, 32'd100);
    push(9'h060, 32'h0000_012C);
    sb.push_back({8'h60, 32'h0000_012C});
    ctl_write(2'd2, 32'd1);
    tick();
    tick();
    early = 0;
    for (int i = 1; i <= 100; i++) begin
      sample_tick = 1'b1;
      if (fm_wren) early = 1;
      tick();
      sample_tick = 1'b0;
      if (i < 100) begin
        repeat (3) begin
          if (fm_wren) early = 1;
          tick();
        end
      end
    end
    check("t2_no_early_write", early, 0);
    lat = 0;
    while (!fm_wren && lat < 10) begin
      tick();
      lat++;
    end
    check("t2_latency_ok", {31'd0, (lat >= 1 && lat <= 3)}, 32'd1);
    repeat (2) tick();
    ctl_write(2'd2, 32'd0);

    // Arbitration: CPU stalled during player WRITE, then wins
    fm_wait = 1'b1;
    ctl_write(2'd2, 32'd1);
    sb.push_back({8'h61, 32'h0000_AAAA});
    sb.push_back({8'h80, 32'h0000_5555});
    sb.push_back({8'h62, 32'h0000_BBBB});
    push(9'h061, 32'h0000_AAAA);
    push(9'h062, 32'h0000_BBBB);
    check("t3_player_wren", {31'd0, fm_wren}, 32'd1);
    check("t3_player_addr", {24'd0, fm_addr}, 32'h61);
    cpu_fm_addr   = 8'h80;
    cpu_fm_wrdata = 32'h0000_5555;
    cpu_fm_wren   = 1'b1;
    #1;
    check("t3_cpu_wait", {31'd0, cpu_fm_wait}, 32'd1);
    check("t3_addr_held", {24'd0, fm_addr}, 32'h61);
    check("t3_data_held", fm_wrdata, 32'h0000_AAAA);
    tick();
    check("t3_cpu_wait_2", {31'd0, cpu_fm_wait}, 32'd1);
    fm_wait = 1'b0;
    tick();
    check("t3_cpu_addr", {24'd0, fm_addr}, 32'h80);
    check("t3_cpu_data", fm_wrdata, 32'h0000_5555);
    check("t3_cpu_wren", {31'd0, fm_wren}, 32'd1);
    check("t3_cpu_nowait", {31'd0, cpu_fm_wait}, 32'd0);
    tick();
    cpu_fm_wren = 1'b0;
    repeat (6) tick();
    ctl_write(2'd2, 32'd0);

    // Overflow: 17 pushes into a 16-deep FIFO
    ctl_write(2'd0, 32'h070);
    for (int i = 0; i < 17; i++) begin
      ctl_write(2'd1, 32'h100 + 32'(i));
      if (i < 16) sb.push_back({8'h70, 32'h100 + 32'(i)});
    end
    ctl_read(2'd2, rd);
    check("t4_status_full", rd, 32'h0000_1014);
    ctl_write(2'd2, 32'd4);
    ctl_read(2'd2, rd);
    check("t4_ovf_cleared", rd, 32'h0000_1010);
    ctl_write(2'd2, 32'd1);
    guard = 0;
    do begin
      tick();
      guard++;
      ctl_read(2'd2, rd);
    end while (!(rd[3] && !rd[1]) && guard < 200);
    check("t4_drain_in_time", {31'd0, (guard < 200)}, 32'd1);
    tick();
    check("t4_all_replayed", sb.size(), 0);

    // Flush during a 50-tick wait
    push(9'h100, 32'd50);
    push(9'h060, 32'h0000_1234);
    ctl_read(2'd2, rd);
    check("t5_status_waiting", rd, 32'h0000_0103);
    ctl_write(2'd2, 32'd3);
    ctl_read(2'd2, rd);
    check("t5_status_flushed", rd, 32'h0000_0009);
    for (int i = 0; i < 6; i++) begin
      sample_tick = 1'b1;
      tick();
      sample_tick = 1'b0;
      tick();
    end
    ctl_read(2'd2, rd);
    check("t5_status_after", rd, 32'h0000_0009);

    // Async reset in the middle of a WRITE
    fm_wait = 1'b1;
    push(9'h065, 32'h0000_DEAD);
    tick();
    tick();
    check("t6_wren_before", {31'd0, fm_wren}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_wren_async", {31'd0, fm_wren}, 32'd0);
    #10;
    reset = 1'b0;
    fm_wait = 1'b0;
    ctl_read(2'd2, rd);
    check("t6_status", rd, 32'h0000_0008);
    repeat (5) tick();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
